// File: rtl/circle_sequencer.sv
// circle_sequencer: command front-end for the circle drawing engine.
// Accepts one circle command over valid/ready, optionally clears the frame
// to a background colour, then holds the engine's level start until done.
// Optional feature macro: CIRCLE_SEQ_CLEAR_EN (frame clear before each circle).
module circle_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_centre_x,
  input  logic [6:0] cmd_centre_y,
  input  logic [7:0] cmd_radius,
  input  logic [2:0] cmd_colour,
  input  logic [2:0] bg_colour,
  output logic       circ_start,
  output logic [7:0] circ_centre_x,
  output logic [6:0] circ_centre_y,
  output logic [7:0] circ_radius,
  output logic [2:0] circ_colour,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_colour_in,
  input  logic       circ_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, RELEASE} state_t;

  typedef struct packed {
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] r;
    logic [2:0] col;
  } circ_cmd_t;

  state_t    state_q, state_d;
  circ_cmd_t cmd_q;
  logic      accept;

  assign accept = cmd_valid && cmd_ready;

`ifdef CIRCLE_SEQ_CLEAR_EN
  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic [2:0] bg_q;
  logic       clr_last;

  assign clr_last = (clr_x == X_MAX) && (clr_y == Y_MAX);

  // Raster scan counters: x fastest, wrap to the next row at the right edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (accept) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (state_q == CLEAR) begin
      if (clr_x == X_MAX) begin
        clr_x <= '0;
        clr_y <= (clr_y == Y_MAX) ? '0 : clr_y + 7'd1;
      end else begin
        clr_x <= clr_x + 8'd1;
      end
    end
  end

  // Background colour is captured with the command it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n)      bg_q <= '0;
    else if (accept) bg_q <= bg_colour;
  end
`else
  // Background colour has no consumer when the clear phase is compiled out.
  logic unused_bg;
  assign unused_bg = ^bg_colour;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Command fields held stable from acceptance until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n)      cmd_q <= '0;
    else if (accept) cmd_q <= '{cx: cmd_centre_x, cy: cmd_centre_y,
                                r: cmd_radius, col: cmd_colour};
  end

  // Next-state: clear (optional), draw until engine done, one release cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef CIRCLE_SEQ_CLEAR_EN
        if (accept) state_d = CLEAR;
`else
        if (accept) state_d = DRAW;
`endif
      end
`ifdef CIRCLE_SEQ_CLEAR_EN
      CLEAR:   if (clr_last) state_d = DRAW;
`endif
      DRAW:    if (circ_done) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // VGA mux: clear pixels, engine pass-through in DRAW, quiet otherwise.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state_q)
`ifdef CIRCLE_SEQ_CLEAR_EN
      CLEAR: begin
        vga_x      = clr_x;
        vga_y      = clr_y;
        vga_colour = bg_q;
        vga_plot   = 1'b1;
      end
`endif
      DRAW: begin
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_colour_in;
        vga_plot   = circ_plot;
      end
      default: ;
    endcase
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == RELEASE);
  assign circ_start    = (state_q == DRAW);
  assign circ_centre_x = cmd_q.cx;
  assign circ_centre_y = cmd_q.cy;
  assign circ_radius   = cmd_q.r;
  assign circ_colour   = cmd_q.col;

endmodule

// File: doc/circle_sequencer.md
# circle_sequencer

Command front-end for the circle drawing engine. Accepts one circle command at a time over a valid/ready handshake. Optionally clears the 160x120 frame to a background colour, then drives the circle engine's level-held `start` until `done`, and releases it. Sits directly upstream of the circle engine and between it and the VGA adapter: it muxes clear-phase pixels and circle-engine pixels onto the single VGA plot port.

## Interface
Parameters:
- `SCREEN_W`, 160, frame width in pixels
- `SCREEN_H`, 120, frame height in pixels

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer idle, command accepted when `cmd_valid && cmd_ready`
- `cmd_centre_x`  in  8  circle centre x
- `cmd_centre_y`  in  7  circle centre y
- `cmd_radius`  in  8  circle radius
- `cmd_colour`  in  3  circle colour
- `bg_colour`  in  3  clear colour, sampled with command
- `circ_start`  out  1  level start to circle engine
- `circ_centre_x`/`circ_centre_y`/`circ_radius`/`circ_colour`  out  8/7/8/3  latched command fields
- `circ_done`  in  1  circle engine done
- `circ_x`/`circ_y`/`circ_colour_in`/`circ_plot`  in  8/7/3/1  circle engine pixel outputs
- `vga_x`/`vga_y`/`vga_colour`/`vga_plot`  out  8/7/3/1  to VGA adapter
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse on command completion

## Operation
- State register with four states: IDLE, CLEAR, DRAW, RELEASE.
- **IDLE:** `cmd_ready=1`, `circ_start=0`, `vga_plot=0`.
  - On handshake, latch all `cmd_*` fields and `bg_colour`.
  - Clear `clr_x`/`clr_y` to 0.
  - Go to CLEAR (macro on) or DRAW (macro off).
- **CLEAR:** `vga_x=clr_x`, `vga_y=clr_y`, `vga_colour=bg_latched`, `vga_plot=1`.
  - `clr_x` increments every cycle.
  - At `clr_x==SCREEN_W-1`: `clr_x` wraps to 0 and `clr_y` increments.
  - At (`SCREEN_W-1`, `SCREEN_H-1`): go to DRAW. Counters are never out of range.
- **DRAW:** `circ_start=1`. `vga_*` pass through `circ_*` combinationally.
  - When `circ_done==1` is sampled, go to RELEASE.
- **RELEASE:** `circ_start=0`, `vga_plot=0`, `done=1` for exactly this cycle, then IDLE.
  - Dropping start returns the engine from its DONE state to its IDLE state.
- Command fields to the engine are held stable from acceptance through RELEASE.
- Commands presented while busy: `cmd_ready=0`; not latched, no effect.
- Off-screen and radius-0 circles need no special handling. Clipping belongs to the circle engine; the sequencer forwards whatever the engine plots.
- Reset mid-operation: state goes to IDLE and counters to 0. `circ_start` drops the same cycle, which also aborts the engine.

## Timing
- Output values after a reset edge:
  - `cmd_ready=1`, `busy=0`, `done=0`, `circ_start=0`.
  - `vga_plot=0`, `vga_x=0`, `vga_y=0`, `vga_colour=0`.
  - `circ_*` latched fields = 0.
- Handshake at edge N → CLEAR at N+1, plotting (0,0) in cycle N+1.
- Clear phase: exactly `SCREEN_W*SCREEN_H` = 19200 cycles, one pixel per cycle. DRAW begins 19200 cycles after the first clear pixel.
- `circ_start` rises in the first DRAW cycle. The engine's pixels appear on `vga_*` with zero added latency.
- `circ_done` high at edge M → RELEASE in cycle M+1 (`done=1`) → IDLE and `cmd_ready=1` in M+2.
- Back-to-back: a new command may be accepted in the first IDLE cycle after RELEASE.
- `circ_done` is ignored outside DRAW.

## Configuration
- `CIRCLE_SEQ_CLEAR_EN`
  - Defined: CLEAR state and counters compiled in; every command clears the frame to `bg_colour` first.
  - Undefined: CLEAR state, `clr_x`/`clr_y` and the `bg_colour` latch are removed. IDLE goes directly to DRAW, with `circ_start` high in the cycle after the handshake. `bg_colour` is unused.

## Test plan
- Reset with `cmd_valid=0` → all outputs at reset values; `cmd_ready=1`.
- Macro on, command (80,60,r=40,colour 2,bg 0):
  - 19200 consecutive plots covering every (x,y) exactly once with colour 0.
  - Then `circ_start=1`; model engine asserts `circ_done` after 500 cycles → `done` pulses once, `circ_start` falls, `cmd_ready` returns 2 cycles after `circ_done`.
- `cmd_valid` held high with changing fields during DRAW → no second acceptance; `circ_centre_x` etc. stay at the first command's values.
- `rst_n` low at clear pixel 5000 → next cycle IDLE; `vga_plot=0`, `circ_start=0`. New command restarts the clear at (0,0).
- Macro off, command (10,10,r=5) → `circ_start=1` the cycle after handshake; zero clear plots; engine pixels pass through unchanged.
- Two commands back-to-back with an always-valid source → second accepted in the first IDLE cycle after RELEASE; both complete with one `done` pulse each.
